sprite_controller: RTL and testbench
====================================

# sprite_controller

Computes the player sprite's on-screen position (`posX`, `posY`) from four push-buttons and feeds the pixel generator stage that composes sprite, enemies and background into RGB. Buttons are synchronised and debounced. Position changes only once per frame, on the frame tick from the VGA timing stage, so a frame never shows a partly moved sprite. Movement is clamped to the visible area unless wrap-around is compiled in.

## Interface
- `START_X`, 320: reset X position (sprite top-left).
- `START_Y`, 400: reset Y position.
- `STEP`, 4: pixels moved per frame per axis.
- `SPRITE_W`, 32: sprite width in pixels.
- `SPRITE_H`, 32: sprite height in pixels.
- `H_ACTIVE`, 640: visible width.
- `V_ACTIVE`, 480: visible height.
- `DEBOUNCE_CYCLES`, 250000: consecutive stable cycles required before a button change is accepted (≥1).
- `clk`  in  1: single clock for the whole block.
- `rst`  in  1: synchronous, active-high reset.
- `btnLeft`, `btnRight`, `btnUp`, `btnDown`  in  1 each: raw, asynchronous, active-high buttons.
- `frameTick`  in  1: one-cycle pulse at the start of vertical blank, synchronous to `clk`.
- `posX`  out  10: sprite X, range 0..XMAX, where XMAX = H_ACTIVE−SPRITE_W (608).
- `posY`  out  10: sprite Y, range 0..YMAX, where YMAX = V_ACTIVE−SPRITE_H (448).
- `moving`  out  1: 1 when the most recent update changed the position.

## Operation
- Per button: 2-flop synchroniser, then a debouncer.
  - The debounced value takes the synchronised value once the synchronised value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any agreement between the two clears the counter.
- Direction: dx = right − left, dy = down − up, each in {−1, 0, +1}. Opposite buttons held together give 0 on that axis.
- FSM:
  - IDLE: all debounced buttons are 0. Go to ARMED when any is 1. `frameTick` is ignored here.
  - ARMED: on `frameTick`, go to UPDATE. Return to IDLE if all buttons drop while no tick is present.
  - UPDATE: lasts exactly one cycle. Loads the new position from dx/dy as sampled in the tick cycle. Then goes to ARMED if any button is held, else IDLE.
- Arithmetic, per axis, with 11-bit signed intermediate:
  - cand = pos + d·STEP.
  - cand < 0 gives 0.
  - cand > MAX gives MAX.
  - Otherwise the result is cand.
- `moving` is loaded in UPDATE with (newX≠posX)|(newY≠posY). It holds until the next UPDATE. It is cleared when entering IDLE.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Timing
- Reset values:
  - `posX` = START_X, `posY` = START_Y, `moving` = 0.
  - Synchronisers, debounced values and counters = 0.
  - FSM = IDLE.
- `rst` overrides everything, including a pending UPDATE. Reset asserted in an UPDATE cycle leaves the reset position, not the computed one.
- Button latency: a raw edge reaches the debounced value 2 + DEBOUNCE_CYCLES edges later.
- Update latency: `frameTick` high in cycle N (FSM in ARMED) puts the new `posX`/`posY`/`moving` on the outputs after edge N+1.
- The debounced value at the cycle of `frameTick` is the one used. A press shorter than a frame and falling entirely between ticks produces no movement.
- A `frameTick` arriving while in UPDATE or IDLE is ignored (no queuing).
- The first tick after the ARMED entry cycle is the first one honoured. A tick in the very cycle IDLE→ARMED is taken is ignored.

## Configuration
- `SPRITE_WRAP_EN` defined: edges wrap.
  - cand < 0 gives MAX. cand > MAX gives 0, per axis.
  - `moving` = 1 on a wrap.
- `SPRITE_WRAP_EN` undefined: clamp behaviour as above. At an edge, pushing outward leaves the position unchanged and `moving` = 0.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and default geometry.
- Reset: assert `rst` 3 cycles → `posX` = 320, `posY` = 400, `moving` = 0. Ticks with no buttons → no change.
- Debounce: `btnRight` glitch high for 3 cycles then low, with ticks applied → `posX` stays 320. Hold high 6+ cycles, then 1 tick → `posX` = 324 exactly 1 cycle after the tick, `moving` = 1.
- Opposite buttons: left+right held, up held, 1 tick → `posX` = 320, `posY` = 396, `moving` = 1.
- Clamp (macro off): right held, 80 ticks → `posX` saturates at 608. The next tick gives `moving` = 0. Down held from posY = 446, 1 tick → 448.
- Wrap (`SPRITE_WRAP_EN`): left held from `posX` = 2, 1 tick → 608. Right held from 606, 1 tick → 0.
- Reset mid-update: `rst` asserted in the cycle after the tick with right held → `posX` = 320, FSM IDLE. After release, the next honoured tick moves to 324.

Source files
------------

// File: rtl/sprite_controller.sv
// sprite_controller: player sprite position from four push-buttons.
// Buttons pass through a 2-flop synchroniser and a down-counting debouncer
// that uses a terminal-count compare. Position changes at most once per frame,
// on frameTick, so a frame never shows a partly moved sprite.
// Define SPRITE_WRAP_EN to make the sprite wrap at the edges; by default it is
// clamped to the visible area.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no debounced button held; frameTick ignored
// ARMED  | at least one button held; waiting for frameTick
// UPDATE | one cycle; load new position from direction latched at tick
module sprite_controller #(
  parameter int START_X         = 320,
  parameter int START_Y         = 400,
  parameter int STEP            = 4,
  parameter int SPRITE_W        = 32,
  parameter int SPRITE_H        = 32,
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnLeft,
  input  logic       btnRight,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       frameTick,
  output logic [9:0] posX,
  output logic [9:0] posY,
  output logic       moving
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LOAD = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [9:0] XMAX = 10'(H_ACTIVE - SPRITE_W);
  localparam logic [9:0] YMAX = 10'(V_ACTIVE - SPRITE_H);
  localparam logic signed [10:0] STEP_S = 11'(STEP);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  // bit order: 0 left, 1 right, 2 up, 3 down
  logic [3:0]    btn_raw;
  logic [3:0]    sync1_q, sync2_q, deb_q;
  logic [CW-1:0] cnt_q [4];

  state_t     state_q, state_d;
  logic [9:0] posx_q, posx_d, posy_q, posy_d;
  logic       moving_q, moving_d;
  logic [3:0] dir_q, dir_d;
  logic       any_btn;
  logic [9:0] new_x, new_y;

  assign btn_raw = {btnDown, btnUp, btnRight, btnLeft};
  assign any_btn = |deb_q;

  // Per-axis move with clamp (or wrap) against the visible area.
  function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic inc,
                                           input logic dec, input logic [9:0] maxv);
    logic signed [10:0] p;
    logic signed [10:0] cand;
    logic signed [10:0] max_s;
    p     = $signed({1'b0, pos});
    max_s = $signed({1'b0, maxv});
    if (inc && !dec)      cand = p + STEP_S;
    else if (dec && !inc) cand = p - STEP_S;
    else                  cand = p;
`ifdef SPRITE_WRAP_EN
    if (cand < 0)          step_axis = maxv;
    else if (cand > max_s) step_axis = '0;
    else                   step_axis = cand[9:0];
`else
    if (cand < 0)          step_axis = '0;
    else if (cand > max_s) step_axis = maxv;
    else                   step_axis = cand[9:0];
`endif
  endfunction

  // Synchronise raw buttons, then accept a change only after it has been
  // stable for DEBOUNCE_CYCLES cycles; the counter loads on any agreement and
  // counts down while the synchronised value differs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= DB_LOAD;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= DB_LOAD;
        end else if (cnt_q[i] == '0) begin
          deb_q[i] <= sync2_q[i];
          cnt_q[i] <= DB_LOAD;
        end else begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
    end
  end

  assign new_x = step_axis(posx_q, dir_q[1], dir_q[0], XMAX);
  assign new_y = step_axis(posy_q, dir_q[3], dir_q[2], YMAX);

  // Next-state and datapath loads for the frame-update FSM.
  always_comb begin
    state_d  = state_q;
    posx_d   = posx_q;
    posy_d   = posy_q;
    moving_d = moving_q;
    dir_d    = dir_q;
    case (state_q)
      S_IDLE: begin
        moving_d = 1'b0;
        if (any_btn) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (frameTick) begin
          state_d = S_UPDATE;
          dir_d   = deb_q;
        end else if (!any_btn) begin
          state_d  = S_IDLE;
          moving_d = 1'b0;
        end
      end
      S_UPDATE: begin
        posx_d   = new_x;
        posy_d   = new_y;
        moving_d = (new_x != posx_q) || (new_y != posy_q);
        state_d  = any_btn ? S_ARMED : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset overrides a pending update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      posx_q   <= 10'(START_X);
      posy_q   <= 10'(START_Y);
      moving_q <= 1'b0;
      dir_q    <= '0;
    end else begin
      state_q  <= state_d;
      posx_q   <= posx_d;
      posy_q   <= posy_d;
      moving_q <= moving_d;
      dir_q    <= dir_d;
    end
  end

  assign posX   = posx_q;
  assign posY   = posy_q;
  assign moving = moving_q;

endmodule

// File: tb/tb_sprite_controller.sv
// Bench for sprite_controller with DEBOUNCE_CYCLES = 4 and default geometry.
// A reference model computes the expected position at each frame tick and
// pushes it to a scoreboard; the entry is popped when the update is visible.
module tb_sprite_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btnLeft = 1'b0, btnRight = 1'b0, btnUp = 1'b0, btnDown = 1'b0;
  logic       frameTick = 1'b0;
  logic [9:0] posX, posY;
  logic       moving;

  sprite_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .btnLeft(btnLeft), .btnRight(btnRight), .btnUp(btnUp), .btnDown(btnDown),
    .frameTick(frameTick),
    .posX(posX), .posY(posY), .moving(moving)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       m;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   mx = 320, my = 400;
  logic mmov = 1'b0;

  function automatic int model_axis(input int pos, input int d, input int maxv);
    int c;
    c = pos + d * 4;
`ifdef SPRITE_WRAP_EN
    if (c < 0) return maxv;
    if (c > maxv) return 0;
`else
    if (c < 0) return 0;
    if (c > maxv) return maxv;
`endif
    return c;
  endfunction

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    mx = 320; my = 400; mmov = 1'b0;
  endtask

  // Pulse frameTick for one cycle. If honoured, the model steps using the
  // buttons the bench is holding (already debounced by then).
  task automatic tick(input bit honoured);
    exp_t e;
    int   nx, ny;
    frameTick = 1'b1;
    @(posedge clk); #1;
    frameTick = 1'b0;
    chk("latency_x", posX, 11'(mx));
    if (honoured) begin
      nx = model_axis(mx, int'(btnRight) - int'(btnLeft), 608);
      ny = model_axis(my, int'(btnDown) - int'(btnUp), 448);
      mmov = (nx != mx) || (ny != my);
      mx = nx; my = ny;
    end
    e.x = 10'(mx); e.y = 10'(my); e.m = mmov;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("pos_x", posX, 11'(e.x));
    chk("pos_y", posY, 11'(e.y));
    chk("moving", moving, 11'(e.m));
  endtask

  initial begin
    // reset state and ticks with no buttons
    do_reset();
    chk("rst_x", posX, 11'd320);
    chk("rst_y", posY, 11'd400);
    chk("rst_moving", moving, 11'd0);
    tick(0);
    tick(0);

    // 3-cycle glitch on right must not move the sprite
    btnRight = 1'b1;
    tick(0);
    cycles(1);
    btnRight = 1'b0;
    tick(0);
    cycles(8);
    tick(0);
    chk("glitch_x", posX, 11'd320);

    // held right, one tick -> 324
    btnRight = 1'b1;
    cycles(10);
    tick(1);
    chk("right_x", posX, 11'd324);
    btnRight = 1'b0;
    cycles(10);
    mmov = 1'b0;
    chk("release_moving", moving, 11'd0);
    tick(0);

    // opposite buttons cancel; up moves
    do_reset();
    btnLeft = 1'b1; btnRight = 1'b1; btnUp = 1'b1;
    cycles(10);
    tick(1);
    chk("opp_x", posX, 11'd320);
    chk("opp_y", posY, 11'd396);
    chk("opp_moving", moving, 11'd1);
    btnLeft = 1'b0; btnRight = 1'b0; btnUp = 1'b0;
    cycles(10);
    mmov = 1'b0;

    // bottom-right edge
    do_reset();
    btnRight = 1'b1; btnDown = 1'b1;
    cycles(10);
    repeat (80) tick(1);
`ifndef SPRITE_WRAP_EN
    chk("sat_x", posX, 11'd608);
    chk("sat_y", posY, 11'd448);
    chk("sat_moving", moving, 11'd0);
`endif
    btnRight = 1'b0; btnDown = 1'b0;
    btnLeft = 1'b1; btnUp = 1'b1;
    cycles(10);
    // top-left edge
    repeat (170) tick(1);
`ifndef SPRITE_WRAP_EN
    chk("sat_x0", posX, 11'd0);
    chk("sat_y0", posY, 11'd0);
`endif
    btnLeft = 1'b0; btnUp = 1'b0;
    cycles(10);
    mmov = 1'b0;

    // reset during UPDATE leaves the reset position
    do_reset();
    btnRight = 1'b1;
    cycles(10);
    frameTick = 1'b1;
    @(posedge clk); #1;
    frameTick = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mx = 320; my = 400; mmov = 1'b0;
    chk("rstupd_x", posX, 11'd320);
    chk("rstupd_moving", moving, 11'd0);
    btnRight = 1'b0;
    cycles(10);
    tick(0);
    btnRight = 1'b1;
    cycles(10);
    tick(1);
    chk("after_rst_x", posX, 11'd324);
    btnRight = 1'b0;
    cycles(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
